gcd_arbiter: RTL

Shares one GCD datapath unit between N requesters. Each requester submits an operand pair on a valid/ready port. The arbiter grants one requester at a time by round-robin and feeds the two operands to the GCD over its 4-phase req/ack load handshake (operand A, then operand B). After a fixed result wait it returns the GCD result to the granted requester. It sits directly in front of the GCD instance and owns its load interface exclusively.

---
 rtl/gcd_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares a single GCD unit between N requesters.
// Each accepted operand pair is fed to the GCD over its 4-phase req/ack load
// port (A, then B). After a fixed wait, the result is returned to the winner.
module gcd_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned RESULT_WAIT = 100
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic [N-1:0]   res_valid,
  input  logic [N-1:0]   res_ready,
  output logic [W-1:0]   res_data,
  output logic           gcd_req,
  input  logic           gcd_ack,
  output logic [W-1:0]   gcd_loadVal,
  input  logic [W-1:0]   gcd_result
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(RESULT_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle, StAReq, StARel, StBReq, StBRel, StWait, StResp
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            accept;
  logic [W-1:0]    sel_a, sel_b;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last_grant_q) + k) % int'(N));
      if (!pick_found && in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Accept strobe is the only combinational output; it is held off during reset.
  always_comb begin
    in_ready = '0;
    if (reset && (state_q == StIdle) && pick_found) begin
      in_ready = N'(1) << pick_idx;
    end
  end

  assign accept = |(in_valid & in_ready);
  assign sel_a  = in_a[pick_idx*W +: W];
  assign sel_b  = in_b[pick_idx*W +: W];

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = sel_a;
          b_d     = sel_b;
          grant_d = pick_idx;
          // gcd(x,0) = x, so a zero operand never needs the GCD unit.
          if ((sel_a == '0) || (sel_b == '0)) begin
            res_d   = sel_a | sel_b;
            state_d = StResp;
          end else begin
            state_d = StAReq;
          end
        end
      end
      StAReq: if (gcd_ack)  state_d = StARel;
      StARel: if (!gcd_ack) state_d = StBReq;
      StBReq: if (gcd_ack)  state_d = StBRel;
      StBRel: begin
        if (!gcd_ack) begin
          cnt_d   = CW'(RESULT_WAIT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          res_d   = gcd_result;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (res_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= IW'(N - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Registered-state decode of the GCD load port and result port.
  always_comb begin
    gcd_req     = 1'b0;
    gcd_loadVal = '0;
    res_valid   = '0;
    res_data    = res_q;
    unique case (state_q)
      StAReq: begin
        gcd_req     = 1'b1;
        gcd_loadVal = a_q;
      end
      StARel: gcd_loadVal = a_q;
      StBReq: begin
        gcd_req     = 1'b1;
        gcd_loadVal = b_q;
      end
      StBRel: gcd_loadVal = b_q;
      StResp: res_valid = N'(1) << grant_q;
      default: ;
    endcase
  end

endmodule
